// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the valid/ready pipeline stage register.
package pipe_stage_skid_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_BUSY  = 2'd1,
    PS_FULL  = 2'd2
  } pipeStageStateType;

  // Number of payload entries held in a given state.
  function automatic logic [1:0] stateOccupancy(input pipeStageStateType s);
    case (s)
      PS_BUSY: return 2'd1;
      PS_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// One valid/ready payload channel; a stage uses one as slave (upstream) and one as master (downstream).
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and optional skid entry.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SKID        = 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     flush,
  pipe_stage_skid_if.slave         upstream,
  pipe_stage_skid_if.master        downstream,
  output logic [1:0]               occupancy
);

  localparam bit HAS_SKID = (SKID != 0);

  pipeStageStateType state, stateNxt;
  logic [WIDTH-1:0]  mainQ;
  logic [WIDTH-1:0]  skidQ;
  logic              inAcc, outAcc;
  logic              loadMain, loadSkid, mainFromSkid;

  assign downstream.valid = (state != PS_EMPTY);
  assign downstream.data  = mainQ;
  assign occupancy        = stateOccupancy(state);
  assign inAcc            = upstream.valid & upstream.ready;
  assign outAcc           = downstream.valid & downstream.ready;

  generate
    if (HAS_SKID) begin : g_skid
      // Ready depends only on registered state, so outReady never reaches inReady combinationally.
      assign upstream.ready = (state != PS_FULL) & ~arst;

      // Skid entry catches the beat accepted in the cycle downstream stalls.
      always_ff @(posedge clk or posedge arst) begin
        if (arst)          skidQ <= RESET_VALUE;
        else if (loadSkid) skidQ <= upstream.data;
      end
    end else begin : g_noskid
      // Single entry: accept only when the held beat leaves this cycle or nothing is held.
      assign upstream.ready = (downstream.ready | ~downstream.valid) & ~arst;
      assign skidQ          = RESET_VALUE;
      logic unusedLoadSkid;
      assign unusedLoadSkid = loadSkid;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= PS_EMPTY;
    else      state <= stateNxt;
  end

  // Next state and load enables; flush wins over every handshake and drops any in-accept.
  always_comb begin
    stateNxt     = state;
    loadMain     = 1'b0;
    loadSkid     = 1'b0;
    mainFromSkid = 1'b0;
    if (flush) begin
      stateNxt = PS_EMPTY;
    end else begin
      case (state)
        PS_EMPTY: begin
          if (inAcc) begin
            stateNxt = PS_BUSY;
            loadMain = 1'b1;
          end
        end
        PS_BUSY: begin
          if (inAcc && outAcc) begin
            loadMain = 1'b1;
          end else if (inAcc && HAS_SKID) begin
            stateNxt = PS_FULL;
            loadSkid = 1'b1;
          end else if (outAcc) begin
            stateNxt = PS_EMPTY;
          end
        end
        PS_FULL: begin
          if (outAcc) begin
            stateNxt     = PS_BUSY;
            mainFromSkid = 1'b1;
          end
        end
        default: stateNxt = PS_EMPTY;
      endcase
    end
  end

  // Main register always feeds outData; it only changes on an accepted load.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)              mainQ <= RESET_VALUE;
    else if (loadMain)     mainQ <= upstream.data;
    else if (mainFromSkid) mainQ <= skidQ;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, synchronous flush and an optional 2-entry skid buffer. It replaces the fixed, always-advancing inter-stage registers of the loopyV core (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block. A stage can stall, be squashed on branch/trap and, with SKID=1, present a registered ready to its upstream stage. Payload is an opaque WIDTH-bit vector: a packed stage struct cast to bits.

## Interface
- WIDTH, 32, payload width in bits (>=1)
- RESET_VALUE, '0, WIDTH-bit value loaded into all payload registers on reset
- SKID, 1, 1: 2-entry skid buffer with registered inReady; 0: single register with combinational inReady
- clk  input  1  core clock, all state on rising edge
- arst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of stage contents, highest priority
- inValid  input  1  upstream payload valid
- inReady  output  1  stage can accept this cycle
- inData  input  WIDTH  upstream payload
- outValid  output  1  stage holds valid payload
- outReady  input  1  downstream accepts this cycle
- outData  output  WIDTH  payload presented downstream
- occupancy  output  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Transfers: in-accept = inValid & inReady; out-accept = outValid & outReady.
- States (stored in the shared enum): PS_EMPTY (0 entries), PS_BUSY (main register holds 1 entry), PS_FULL (main plus skid register hold 2 entries; SKID=1 only).
- outData always equals the main register; outValid = (state != PS_EMPTY).
- inReady:
  - SKID=1: (state != PS_FULL) & !arst. Registered-state derived; no combinational path from outReady.
  - SKID=0: (outReady | !outValid) & !arst.
- Transitions when flush=0:
  - PS_EMPTY: in-accept -> PS_BUSY, main<=inData.
  - PS_BUSY, in-accept & out-accept -> PS_BUSY, main<=inData.
  - PS_BUSY, in-accept & !out-accept -> PS_FULL, skid<=inData. With SKID=0 this case cannot occur, because inReady is 0.
  - PS_BUSY, !in-accept & out-accept -> PS_EMPTY.
  - PS_FULL: out-accept -> PS_BUSY, main<=skid. No input is possible since inReady=0.
  - Any other combination holds state and data.
- flush=1: next state PS_EMPTY regardless of handshakes.
  - An in-accept in the same cycle is dropped.
  - Payload registers keep their values; outData is don't-care while outValid=0.
- Ordering: strict FIFO. No payload is duplicated or lost except on flush.
- Stable-data rule: while outValid=1 and outReady=0, outData does not change.

## Timing
- Reset (arst=1, asynchronous): state PS_EMPTY, main=skid=RESET_VALUE, outValid=0, occupancy=0, outData=RESET_VALUE, inReady=0. First acceptance is possible on the first rising edge after arst deasserts.
- Latency: an in-accept at edge N gives outValid=1 and outData valid after edge N, i.e. 1 cycle into an empty stage.
- Throughput: 1 transfer/cycle sustained when outReady=1, in both modes.
- SKID=1 backpressure: outReady falling costs at most one extra absorbed beat; inReady falls the cycle after the stage reaches PS_FULL.
- Flush: outValid=0 in the cycle after the flush edge. inReady=1 in that cycle in both modes.
- Reset asserted mid-transfer: contents are discarded immediately and asynchronously; no partial state survives.

## Structure
- Add to loopyV_data_types:
  - typedef enum logic [1:0] {PS_EMPTY, PS_BUSY, PS_FULL} pipeStageStateType
  - packed versions of the stage structs, so WIDTH = $bits(struct) at instantiation
- Single module with no sub-module. SKID selects logic through a generate branch; the skid register is not instantiated when SKID=0.
- Operand muxing and decode stay outside; this block only stores and forwards.

## Test plan
- Reset: hold arst=1 with inValid=1, inData=32'hDEAD_BEEF -> outValid=0, outData=0, inReady=0, occupancy=0; first accepted word appears one cycle after release.
- Streaming: SKID=1, outReady=1, push 0x1..0x8 on consecutive cycles -> outData=0x1..0x8 on consecutive cycles starting 1 cycle later, occupancy=1 throughout.
- Backpressure: SKID=1, drop outReady while pushing 0xA,0xB,0xC -> state PS_FULL holding 0xA/0xB, inReady=0 next cycle, 0xC held upstream; raising outReady then delivers 0xA,0xB,0xC in order with no gaps.
- Flush collision: in PS_FULL, assert flush with outReady=1 and inValid=1 (data 0x55) -> next cycle outValid=0, occupancy=0, and 0x55 never appears at the output.
- SKID=0 comparison: same stimulus as the backpressure test -> inReady follows outReady combinationally and occupancy never exceeds 1.
- Random: WIDTH=7, random inValid/outReady/flush -> scoreboard FIFO order and stable-data rule hold, and throughput matches an ideal 2-deep queue model.
